// File: rtl/extend_scheduler.sv
// extend_scheduler: sequences each job's fragment parts and k-mer indices to the extender; EXT_SCHED_PERF_EN enables perf counters
module extend_scheduler #(
  parameter int FRAG_LEN_BITS = 8,
  parameter int FRAG_PART = 4,
  parameter int INDICES_COUNT = 4,
  parameter int INDICE_LEN = 3,
  localparam int FRAG_PARTS_COUNT = FRAG_LEN_BITS / FRAG_PART,
  localparam int PB = FRAG_PARTS_COUNT > 1 ? $clog2(FRAG_PARTS_COUNT) : 1,
  localparam int IB = INDICES_COUNT > 1 ? $clog2(INDICES_COUNT) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic [FRAG_LEN_BITS-1:0] in_fragment,
  input  logic [INDICES_COUNT-1:0][INDICE_LEN-1:0] in_kmer_indices,
  output logic [FRAG_LEN_BITS-1:0] ext_fragment,
  output logic [INDICES_COUNT-1:0][INDICE_LEN-1:0] ext_kmer_indices,
  output logic [PB-1:0] ext_part_sel,
  output logic [IB-1:0] ext_idx_sel,
  output logic out_valid,
  input  logic out_ready,
  output logic out_last,
  output logic [15:0] perf_jobs,
  output logic [15:0] perf_stalls
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic part_max;
  assign part_max = ext_part_sel == PB'(FRAG_PARTS_COUNT - 1);
  assign out_valid = state == RUN;
  assign out_last = out_valid && part_max && ext_idx_sel == IB'(INDICES_COUNT - 1);
  assign in_ready = state == IDLE || (out_last && out_ready);
  // Accepting a job (from IDLE or on the last beat) wins over stepping the beat counters
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ext_fragment <= '0;
      ext_kmer_indices <= '0;
      ext_part_sel <= '0;
      ext_idx_sel <= '0;
    end else if (in_valid && in_ready) begin
      state <= RUN;
      ext_fragment <= in_fragment;
      ext_kmer_indices <= in_kmer_indices;
      ext_part_sel <= '0;
      ext_idx_sel <= '0;
    end else if (out_valid && out_ready) begin
      if (out_last) begin
        state <= IDLE;
        ext_part_sel <= '0;
        ext_idx_sel <= '0;
      end else begin
        ext_part_sel <= part_max ? '0 : ext_part_sel + PB'(1);
        ext_idx_sel <= part_max ? ext_idx_sel + IB'(1) : ext_idx_sel;
      end
    end
`ifdef EXT_SCHED_PERF_EN
  // Saturating counts of finished jobs and stalled beats
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_jobs <= '0;
      perf_stalls <= '0;
    end else begin
      if (out_last && out_ready && perf_jobs != 16'hFFFF) perf_jobs <= perf_jobs + 16'd1;
      if (out_valid && !out_ready && perf_stalls != 16'hFFFF) perf_stalls <= perf_stalls + 16'd1;
    end
`else
  assign perf_jobs = '0;
  assign perf_stalls = '0;
`endif
endmodule

// File: doc/extend_scheduler.md
EXTEND_SCHEDULER -- requirements
Module: extend_scheduler

Interface
REQ-001 SHALL have parameter FRAG_LEN_BITS, default 8, meaning fragment width in bits.
REQ-002 SHALL have parameter FRAG_PART, default 4, meaning bits per fragment part; FRAG_PARTS_COUNT = FRAG_LEN_BITS/FRAG_PART (default 2), PB = max(1, clog2(FRAG_PARTS_COUNT)).
REQ-003 SHALL have parameter INDICES_COUNT, default 4, meaning k-mer indices per job; IB = max(1, clog2(INDICES_COUNT)).
REQ-004 SHALL have parameter INDICE_LEN, default 3, meaning width of one k-mer index.
REQ-005 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port in_valid  input  1  job offered.
REQ-008 SHALL have port in_ready  output  1  job accepted when in_valid && in_ready.
REQ-009 SHALL have port in_fragment  input  FRAG_LEN_BITS  job fragment.
REQ-010 SHALL have port in_kmer_indices  input  INDICES_COUNT x INDICE_LEN  job indices.
REQ-011 SHALL have port ext_fragment  output  FRAG_LEN_BITS  registered fragment to extender datapath.
REQ-012 SHALL have port ext_kmer_indices  output  INDICES_COUNT x INDICE_LEN  registered indices to extender.
REQ-013 SHALL have port ext_part_sel  output  PB  current fragment-part select.
REQ-014 SHALL have port ext_idx_sel  output  IB  current index select.
REQ-015 SHALL have port out_valid  output  1  current beat valid.
REQ-016 SHALL have port out_ready  input  1  downstream accepts beat.
REQ-017 SHALL have port out_last  output  1  final beat of job.
REQ-018 SHALL have port perf_jobs  output  16  completed-job count.
REQ-019 SHALL have port perf_stalls  output  16  stalled-beat count.

Function
REQ-020 SHALL implement FSM states IDLE and RUN.
REQ-021 IDLE: in_ready=1, out_valid=0; on in_valid, capture in_fragment/in_kmer_indices into ext_* registers, clear both selects, go RUN next cycle.
REQ-022 RUN: out_valid=1; beat transfers on out_valid && out_ready; no transfer -> all state held (stall).
REQ-023 On transfer: ext_part_sel increments; at FRAG_PARTS_COUNT-1 wraps to 0 and ext_idx_sel increments.
REQ-024 out_last SHALL be 1 iff RUN && ext_part_sel==FRAG_PARTS_COUNT-1 && ext_idx_sel==INDICES_COUNT-1; job = FRAG_PARTS_COUNT*INDICES_COUNT beats (default 8).
REQ-025 In RUN, in_ready = out_last && out_ready (combinational); otherwise 0.
REQ-026 Last-beat transfer with in_valid=1: capture new job, clear selects, stay RUN; zero bubble between jobs.
REQ-027 Last-beat transfer with in_valid=0: go IDLE, selects cleared, ext_* registers hold.
REQ-028 ext_* registers SHALL change only on accepted job; in_fragment changes while not accepted SHALL be ignored.
REQ-029 Latency: accept in cycle N -> first out_valid in cycle N+1.
REQ-030 perf_jobs SHALL increment on each last-beat transfer; perf_stalls on each RUN cycle with out_ready=0; both saturate at 16'hFFFF.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, selects=0, ext_fragment=0, ext_kmer_indices=0, perf counters=0; thus out_valid=0, out_last=0, in_ready=1 during reset.
REQ-032 Reset mid-job SHALL discard the job without emitting remaining beats; first cycle after release is IDLE.

Configuration
REQ-033 Macro EXT_SCHED_PERF_EN defined: perf_jobs/perf_stalls counters per REQ-030.
REQ-034 Macro EXT_SCHED_PERF_EN undefined: no counter logic; perf_jobs and perf_stalls SHALL be constant 0; all other behaviour identical.

Verification
REQ-035 Single job: in_fragment=8'hB4, indices {3,1,6,2}, out_ready=1 -> 8 beats, (idx,part) = (0,0),(0,1),(1,0)...(3,1), out_last only on 8th, then IDLE.
REQ-036 Back-to-back: second job valid during last beat -> accepted that cycle, its first beat next cycle, no out_valid gap.
REQ-037 Backpressure: out_ready=0 for 3 cycles at beat 4 -> selects frozen at (1,1), perf_stalls=3 (macro on), beat order unchanged.
REQ-038 Reset at beat 5 -> out_valid=0 immediately, selects=0, in_ready=1; next job starts at (0,0).
REQ-039 Macro off: run 2 jobs -> perf_jobs=0, perf_stalls=0; macro on -> perf_jobs=2.
REQ-040 Input change while RUN non-last: in_fragment altered -> ext_fragment unchanged, in_ready=0.
